// File: rtl/accum_div.sv
// Restoring divider: STEPS quotient bits per cycle, MSB first, valid/ready on both sides.
// Optional divide-by-zero fast path and flag under `ACCUM_DIV_DBZ_EN.
module accum_div #(
   parameter int BITS_N = 512,
   parameter int BITS_D = 256,
   parameter int STEPS  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [BITS_N-1:0] i_dat_n,
   input  logic [BITS_D-1:0] i_dat_d,
   input  logic              i_val,
   output logic              o_rdy,
   output logic [BITS_N-1:0] o_quo,
   output logic [BITS_D-1:0] o_rem,
   output logic              o_dbz,
   output logic              o_val,
   input  logic              i_rdy
);

   localparam int CNT_W = $clog2(BITS_N + 1);

   if (((BITS_N % STEPS) != 0) || (BITS_D > BITS_N)) begin : g_bad_param
      $error("accum_div: STEPS must divide BITS_N and BITS_D must not exceed BITS_N");
   end

   typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BITS_D-1:0] rem_q, rem_d;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [BITS_N-1:0] nq_q, nq_d;
   logic [BITS_D-1:0] den_q, den_d;
   logic [BITS_N-1:0] o_quo_q, o_quo_d;
   logic [BITS_D-1:0] o_rem_q, o_rem_d;
   logic              o_val_q, o_val_d;
   logic              o_rdy_q, o_rdy_d;
`ifdef ACCUM_DIV_DBZ_EN
   logic              dbz_q, dbz_d;
   logic              o_dbz_q, o_dbz_d;
`endif

   logic [BITS_D:0]   step_r;
   logic [BITS_N-1:0] step_nq;

   // The extra top bit of step_r holds the carry of the shift; after a step it is always 0.
   always_comb begin
      step_r  = {1'b0, rem_q};
      step_nq = nq_q;
      for (int i = 0; i < STEPS; i++) begin
         step_r  = {step_r[BITS_D-1:0], step_nq[BITS_N-1]};
         step_nq = {step_nq[BITS_N-2:0], 1'b0};
         if (step_r >= {1'b0, den_q}) begin
            step_r     = step_r - {1'b0, den_q};
            step_nq[0] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      nq_d    = nq_q;
      den_d   = den_q;
      o_quo_d = o_quo_q;
      o_rem_d = o_rem_q;
      o_val_d = o_val_q;
      o_rdy_d = o_rdy_q;
`ifdef ACCUM_DIV_DBZ_EN
      dbz_d   = dbz_q;
      o_dbz_d = o_dbz_q;
`endif
      case (state_q)
         IDLE: begin
            o_rdy_d = 1'b1;
            if (o_rdy_q && i_val) begin
               nq_d    = i_dat_n;
               den_d   = i_dat_d;
               rem_d   = '0;
               cnt_d   = '0;
               o_rdy_d = 1'b0;
               o_val_d = 1'b0;
               state_d = DIV;
`ifdef ACCUM_DIV_DBZ_EN
               dbz_d = (i_dat_d == '0);
               if (i_dat_d == '0) begin
                  nq_d    = '1;
                  rem_d   = i_dat_n[BITS_D-1:0];
                  state_d = FINISH;
               end
`endif
            end
         end
         DIV: begin
            rem_d = step_r[BITS_D-1:0];
            nq_d  = step_nq;
            cnt_d = cnt_q + CNT_W'(STEPS);
            if (cnt_d == CNT_W'(BITS_N)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (!o_val_q) begin
               o_quo_d = nq_q;
               o_rem_d = rem_q;
               o_val_d = 1'b1;
`ifdef ACCUM_DIV_DBZ_EN
               o_dbz_d = dbz_q;
`endif
            end else if (i_rdy) begin
               o_val_d = 1'b0;
               o_rdy_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         nq_q    <= '0;
         den_q   <= '0;
         o_quo_q <= '0;
         o_rem_q <= '0;
         o_val_q <= 1'b0;
         o_rdy_q <= 1'b0;
`ifdef ACCUM_DIV_DBZ_EN
         dbz_q   <= 1'b0;
         o_dbz_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         nq_q    <= nq_d;
         den_q   <= den_d;
         o_quo_q <= o_quo_d;
         o_rem_q <= o_rem_d;
         o_val_q <= o_val_d;
         o_rdy_q <= o_rdy_d;
`ifdef ACCUM_DIV_DBZ_EN
         dbz_q   <= dbz_d;
         o_dbz_q <= o_dbz_d;
`endif
      end
   end

   assign o_quo = o_quo_q;
   assign o_rem = o_rem_q;
   assign o_val = o_val_q;
   assign o_rdy = o_rdy_q;
`ifdef ACCUM_DIV_DBZ_EN
   assign o_dbz = o_dbz_q;
`else
   assign o_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_accum_div.sv
// Bench for accum_div: two instances (STEPS=1 and STEPS=4), directed corner cases plus random
// operations checked against plain integer division; honours ACCUM_DIV_DBZ_EN.
module tb_accum_div;

   localparam int N = 16;
   localparam int D = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [1:0]          vl;
   logic [1:0]          rin;
   logic [1:0][N-1:0]   dn;
   logic [1:0][D-1:0]   dd;
   wire  [1:0]          ordy;
   wire  [1:0]          oval;
   wire  [1:0]          odbz;
   wire  [1:0][N-1:0]   oquo;
   wire  [1:0][D-1:0]   orem;

   int n_chk = 0;
   int n_err = 0;

   accum_div #(.BITS_N(N), .BITS_D(D), .STEPS(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_dat_n(dn[0]), .i_dat_d(dd[0]), .i_val(vl[0]),
      .o_rdy(ordy[0]), .o_quo(oquo[0]), .o_rem(orem[0]), .o_dbz(odbz[0]),
      .o_val(oval[0]), .i_rdy(rin[0])
   );

   accum_div #(.BITS_N(N), .BITS_D(D), .STEPS(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_dat_n(dn[1]), .i_dat_d(dd[1]), .i_val(vl[1]),
      .o_rdy(ordy[1]), .o_quo(oquo[1]), .o_rem(orem[1]), .o_dbz(odbz[1]),
      .o_val(oval[1]), .i_rdy(rin[1])
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int sel, input logic [N-1:0] n, input logic [D-1:0] d,
                         input int hold);
      int          lat;
      int          wt;
      int          k;
      int          elat;
      logic [N-1:0] eq;
      logic [D-1:0] er;
      logic        edbz;
      bit          chkdat;
      k = (sel == 0) ? N : N / 4;
      if (d != '0) begin
         eq     = n / N'(d);
         er     = D'(n % N'(d));
         edbz   = 1'b0;
         elat   = k + 1;
         chkdat = 1'b1;
      end else begin
`ifdef ACCUM_DIV_DBZ_EN
         eq     = '1;
         er     = n[D-1:0];
         edbz   = 1'b1;
         elat   = 1;
         chkdat = 1'b1;
`else
         eq     = '0;
         er     = '0;
         edbz   = 1'b0;
         elat   = k + 1;
         chkdat = 1'b0;
`endif
      end
      wt = 0;
      while (!ordy[sel] && wt < 100) begin
         tick();
         wt++;
      end
      check("rdy_wait", 32'(ordy[sel]), 32'd1);
      dn[sel]  = n;
      dd[sel]  = d;
      vl[sel]  = 1'b1;
      rin[sel] = (hold == 0);
      tick();
      vl[sel] = 1'b0;
      dn[sel] = N'($urandom);
      dd[sel] = D'($urandom);
      check("busy_rdy", 32'(ordy[sel]), 32'd0);
      lat = 0;
      while (!oval[sel] && lat < 200) begin
         vl[sel] = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      vl[sel] = 1'b0;
      check("latency", 32'(lat), 32'(elat));
      check("dbz", 32'(odbz[sel]), 32'(edbz));
      if (chkdat) begin
         check("quo", 32'(oquo[sel]), 32'(eq));
         check("rem", 32'(orem[sel]), 32'(er));
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_val", 32'(oval[sel]), 32'd1);
         if (chkdat) begin
            check("hold_quo", 32'(oquo[sel]), 32'(eq));
            check("hold_rem", 32'(orem[sel]), 32'(er));
         end
      end
      rin[sel] = 1'b1;
      tick();
      check("drop_val", 32'(oval[sel]), 32'd0);
      check("rdy_back", 32'(ordy[sel]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int stale;
      int sel;
      logic [N-1:0] rn;
      logic [D-1:0] rd;
      rst = 1'b1;
      vl  = '0;
      rin = '1;
      dn  = '0;
      dd  = '0;
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         check("rst_val", 32'(oval[s]), 32'd0);
         check("rst_rdy", 32'(ordy[s]), 32'd0);
         check("rst_quo", 32'(oquo[s]), 32'd0);
         check("rst_rem", 32'(orem[s]), 32'd0);
         check("rst_dbz", 32'(odbz[s]), 32'd0);
      end
      rst = 1'b0;
      tick();
      check("rdy_after_rst", 32'(ordy[0]), 32'd1);

      run_op(0, 16'd1000, 8'd7, 0);
      run_op(1, 16'hFFFF, 8'hFF, 0);
      run_op(0, 16'd50, 8'd9, 10);
      run_op(0, 16'd3, 8'd200, 0);
      run_op(0, 16'hABCD, 8'd1, 0);
      run_op(0, 16'h1234, 8'd0, 0);
      run_op(1, 16'h1234, 8'd0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_extra_val", 32'(oval[0]), 32'd0);
      end

      // Abort an operation partway through DIV.
      dn[0] = 16'd777;
      dd[0] = 8'd5;
      vl[0] = 1'b1;
      tick();
      vl[0] = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst = 1'b1;
      tick();
      check("abort_val", 32'(oval[0]), 32'd0);
      check("abort_rdy", 32'(ordy[0]), 32'd0);
      rst   = 1'b0;
      stale = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (oval[0]) stale++;
      end
      check("stale_val", 32'(stale), 32'd0);
      run_op(0, 16'd100, 8'd10, 0);

      for (int i = 0; i < 24; i++) begin
         sel = int'($urandom_range(0, 1));
         rn  = N'($urandom);
         rd  = ($urandom_range(0, 9) == 0) ? '0 : D'($urandom);
         run_op(sel, rn, rd, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/accum_div.md
Name: accum_div

Overview:
- Multi-cycle restoring divider: takes a wide dividend (e.g. a 2N-bit product from the multiplier) and an N-bit divisor, and returns quotient and remainder.
- It is the inverse-direction companion of the accumulating multiplier and uses the same valid/ready handshake on both sides, so it chains directly behind it.
- It processes STEPS quotient bits per cycle, MSB first. Used for reduction/normalisation paths in the ZKP datapath.

Parameters:
- BITS_N, 512, dividend and quotient width.
- BITS_D, 256, divisor and remainder width; BITS_D <= BITS_N.
- STEPS, 1, quotient bits resolved per cycle. Must divide BITS_N; elaboration error otherwise.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_dat_n  in  BITS_N  dividend.
- i_dat_d  in  BITS_D  divisor.
- i_val  in  1  input valid.
- o_rdy  out  1  ready to accept an operation.
- o_quo  out  BITS_N  quotient.
- o_rem  out  BITS_D  remainder.
- o_dbz  out  1  divide-by-zero flag, valid with o_val (see Optional Feature).
- o_val  out  1  result valid.
- i_rdy  in  1  downstream ready.

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk. In reset, o_quo=0, o_rem=0, o_dbz=0, o_val=0, o_rdy=0, state=IDLE, iteration counter=0, partial remainder=0.
- Reset asserted in any state, including mid-DIV or in FINISH with o_val high, aborts the operation. No result is emitted.
- States: IDLE, DIV, FINISH.
- IDLE:
  - o_rdy is driven 1 from the first cycle after reset release.
  - Accept occurs on a clock edge with o_rdy && i_val. At that edge: latch dividend and divisor, clear partial remainder (BITS_D+1 bits) and quotient, counter=0, o_rdy<=0, o_val<=0.
  - Next state is DIV.
- DIV: each cycle performs STEPS restoring steps, MSB first. For each step:
  - r = {r[BITS_D-1:0], next dividend bit}.
  - If r >= {1'b0,d}: r = r - d and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter advances by STEPS per cycle. After BITS_N/STEPS cycles, next state is FINISH.
- Partial remainder width is BITS_D+1 so the shift never loses a carry. The subtract result always fits in BITS_D bits.
- FINISH:
  - First cycle: o_quo and o_rem are loaded and o_val<=1.
  - o_val, o_quo, o_rem and o_dbz hold stable while o_val && !i_rdy.
  - On an edge with o_val && i_rdy: o_val<=0, o_rdy<=1, next state is IDLE.
- Latency: o_val rises BITS_N/STEPS+1 edges after the accept edge.
- Throughput: one operation per BITS_N/STEPS+3 cycles when i_rdy is held high.
- i_val while o_rdy=0 is ignored. Input data is sampled only at the accept edge, so later changes to i_dat_n/i_dat_d do not affect the operation in flight.
- i_rdy while o_val=0 is ignored.
- Outputs keep their last values in IDLE until the next result overwrites them. Downstream must qualify them with o_val only.
- Dividend < divisor: quotient is 0 and remainder equals the dividend.
- Divisor of 1: quotient equals the dividend and remainder is 0.

Optional Feature:
- Macro: ACCUM_DIV_DBZ_EN.
- When defined:
  - At the accept edge, divisor==0 skips DIV and goes straight to FINISH.
  - Result: o_quo = all ones, o_rem = i_dat_n[BITS_D-1:0], o_dbz=1.
  - o_val rises 1 edge after accept.
  - o_dbz is 0 for every nonzero divisor.
- When undefined:
  - o_dbz is tied 0.
  - A zero divisor runs the full BITS_N/STEPS iterations with normal latency.
  - o_quo/o_rem contents are unspecified, but the handshake is fully preserved.

Test Plan:
- BITS_N=16, BITS_D=8, STEPS=1: n=1000, d=7, i_rdy=1. Require o_quo=142, o_rem=6, o_val exactly 17 edges after accept, asserted 1 cycle, o_rdy back to 1 the next cycle.
- Same params with STEPS=4: n=0xFFFF, d=0xFF. Require o_quo=257, o_rem=0, latency 5 edges.
- Backpressure: n=50, d=9 with i_rdy=0 for 10 cycles after o_val. Require o_quo=5, o_rem=5 held stable and o_val high throughout. Release i_rdy: o_val drops and o_rdy rises on the next edge.
- Boundaries:
  - n=3, d=200 gives quotient 0, remainder 3.
  - n=0xABCD, d=1 gives quotient 0xABCD, remainder 0.
  - i_val pulsed while busy is ignored, with exactly one result out.
- Reset mid-operation: assert i_rst at DIV cycle 8, then issue n=100, d=10. Require no stale o_val, then quotient 10, remainder 0 with normal latency.
- Divide by zero: with ACCUM_DIV_DBZ_EN, n=0x1234, d=0 gives o_quo=0xFFFF, o_rem=0x34, o_dbz=1, o_val 1 edge after accept. Without the macro, o_dbz=0 and latency is 17.
